// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the IF/MEM memory port arbiter: FSM states, grant owner,
// and the wait-counter width rule.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_BUSY = 2'd1,
        ST_D_BUSY  = 2'd2
    } arb_state_e;

    typedef enum logic {
        GRANT_IF = 1'b0,
        GRANT_D  = 1'b1
    } grant_e;

    // One spare bit so MEM_LAT-1 always fits, including MEM_LAT=1.
    function automatic int cnt_width(input int mem_lat);
        return $clog2(mem_lat) + 1;
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-state counter for one memory transaction: loads MEM_LAT-1 on grant,
// counts down while busy and flags zero in the final access cycle.
module mem_wait_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // NOTE: sequential state is assigned with <= only; reset is synchronous and active-low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between instruction
// fetch and the data stage, with registered memory/ready outputs and pipeline holds.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              pc_hold,
    output logic              pipe_hold
);

    localparam int CNT_W = cnt_width(MEM_LAT);

    generate
        if (MEM_LAT < 1) begin : g_bad_lat
            $error("mem_port_arbiter: MEM_LAT must be >= 1");
        end
    endgenerate

    arb_state_e        state_q;
    grant_e            last_grant_q;
    logic              is_write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              if_ready_q;
    logic              d_ready_q;

    logic             d_req;
    logic             busy;
    logic             grant_valid;
    logic             grant_d;
    logic             cnt_zero;
    logic [CNT_W-1:0] cnt;

    assign d_req = d_read | d_write;
    assign busy  = (state_q != ST_IDLE);

    // A ready pulse blocks granting for one cycle so the finished requester can retire.
    assign grant_valid = (state_q == ST_IDLE) && !if_ready_q && !d_ready_q && (if_req || d_req);
    assign grant_d     = d_req && (!if_req || (last_grant_q == GRANT_IF));

    mem_wait_counter #(
        .CNT_W (CNT_W)
    ) u_wait_counter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (grant_valid),
        .load_val_i (CNT_W'(MEM_LAT - 1)),
        .dec_i      (busy),
        .cnt_o      (cnt),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_IF;
            is_write_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            if_ready_q   <= 1'b0;
            d_ready_q    <= 1'b0;
        end else begin
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_valid) begin
                        mem_addr_q   <= grant_d ? d_addr : if_addr;
                        mem_wdata_q  <= d_wdata;
                        is_write_q   <= grant_d && d_write;
                        mem_read_q   <= !(grant_d && d_write);
                        mem_write_q  <= grant_d && d_write && (MEM_LAT == 1);
                        state_q      <= grant_d ? ST_D_BUSY : ST_IF_BUSY;
                        last_grant_q <= grant_d ? GRANT_D : GRANT_IF;
                    end
                end
                ST_IF_BUSY, ST_D_BUSY: begin
                    if (cnt_zero) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        state_q     <= ST_IDLE;
                        if (state_q == ST_IF_BUSY) begin
                            if_rdata_q <= mem_rdata;
                            if_ready_q <= 1'b1;
                        end else begin
                            if (!is_write_q) begin
                                d_rdata_q <= mem_rdata;
                            end
                            d_ready_q <= 1'b1;
                        end
                    end else begin
                        // The single write strobe lands in the final access cycle.
                        mem_write_q <= is_write_q && (cnt == CNT_W'(1));
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_ready  = if_ready_q;
    assign d_ready   = d_ready_q;

    assign pipe_hold = d_req & ~d_ready_q;
    assign pc_hold   = (if_req & ~if_ready_q) | pipe_hold;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed cycle traces (MEM_LAT=2 and MEM_LAT=1)
// plus randomized fetch/data traffic checked by a queue-based scoreboard.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int LAT = 2;

    typedef struct packed {
        logic        is_store;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        if_req, d_read, d_write;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_ready, d_ready, mem_read, mem_write, pc_hold, pipe_hold;

    logic        l1_if_req, l1_d_read, l1_d_write;
    logic [31:0] l1_if_addr, l1_d_addr, l1_d_wdata, l1_mem_rdata;
    logic [31:0] l1_if_rdata, l1_d_rdata, l1_mem_addr, l1_mem_wdata;
    logic        l1_if_ready, l1_d_ready, l1_mem_read, l1_mem_write, l1_pc_hold, l1_pipe_hold;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata(mem_rdata), .pc_hold(pc_hold), .pipe_hold(pipe_hold)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_l1 (
        .clk(clk), .rst(rst),
        .if_req(l1_if_req), .if_addr(l1_if_addr), .if_rdata(l1_if_rdata), .if_ready(l1_if_ready),
        .d_read(l1_d_read), .d_write(l1_d_write), .d_addr(l1_d_addr), .d_wdata(l1_d_wdata),
        .d_rdata(l1_d_rdata), .d_ready(l1_d_ready),
        .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata), .mem_read(l1_mem_read),
        .mem_write(l1_mem_write), .mem_rdata(l1_mem_rdata),
        .pc_hold(l1_pc_hold), .pipe_hold(l1_pipe_hold)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
    endfunction

    // Memory models: data returned while a read is active, writes applied on the strobe.
    logic [31:0] phys [logic [31:0]];

    function automatic logic [31:0] phys_rd(input logic [31:0] a);
        return phys.exists(a) ? phys[a] : init_word(a);
    endfunction

    always @(negedge clk) begin
        if (mem_write) phys[mem_addr] = mem_wdata;
        mem_rdata    <= mem_read ? phys_rd(mem_addr) : 32'h0;
        l1_mem_rdata <= l1_mem_read ? init_word(l1_mem_addr) : 32'h0;
    end

    // Directed trace capture for the MEM_LAT=2 instance; bit k is cycle k.
    logic [15:0] t_mrd, t_mwr, t_ifr, t_dr, t_pch, t_pph;
    logic [31:0] t_maddr [16];
    logic [31:0] t_mwd   [16];
    logic [31:0] t_ifd   [16];
    logic [31:0] t_dd    [16];

    task automatic trace(input int n);
        t_mrd = '0; t_mwr = '0; t_ifr = '0; t_dr = '0; t_pch = '0; t_pph = '0;
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin
                tick();
                if (t_ifr[k-1]) if_req = 1'b0;
                if (t_dr[k-1]) begin d_read = 1'b0; d_write = 1'b0; end
            end
            #1;
            t_mrd[k] = mem_read;   t_mwr[k] = mem_write;
            t_ifr[k] = if_ready;   t_dr[k]  = d_ready;
            t_pch[k] = pc_hold;    t_pph[k] = pipe_hold;
            t_maddr[k] = mem_addr; t_mwd[k] = mem_wdata;
            t_ifd[k] = if_rdata;   t_dd[k]  = d_rdata;
        end
    endtask

    // Scoreboard: drivers push expectations, the monitor pops on each ready pulse.
    exp_t        if_q[$];
    exp_t        d_q[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] d_last;
    bit          mon_en = 1'b0;
    int          rd_cnt, wr_cnt;
    logic [31:0] rd_addr, wr_addr, wr_data;
    exp_t        e_if, e_d;

    always @(negedge clk) begin
        if (mon_en) begin
            check("pipe_hold", pipe_hold, (d_read | d_write) & ~d_ready);
            check("pc_hold", pc_hold, (if_req & ~if_ready) | ((d_read | d_write) & ~d_ready));
            check("rd_wr_exclusive", mem_read & mem_write, 1'b0);
            check("ready_exclusive", if_ready & d_ready, 1'b0);
            if (mem_read) begin rd_cnt++; rd_addr = mem_addr; end
            if (mem_write) begin wr_cnt++; wr_addr = mem_addr; wr_data = mem_wdata; end
            if (if_ready) begin
                check("if_expected", if_q.size() != 0, 1'b1);
                if (if_q.size() != 0) begin
                    e_if = if_q.pop_front();
                    check("if_rdata", if_rdata, e_if.rdata);
                    check("if_rd_cycles", rd_cnt, LAT);
                    check("if_wr_cycles", wr_cnt, 0);
                    check("if_mem_addr", rd_addr, e_if.addr);
                end
                rd_cnt = 0; wr_cnt = 0;
            end
            if (d_ready) begin
                check("d_expected", d_q.size() != 0, 1'b1);
                if (d_q.size() != 0) begin
                    e_d = d_q.pop_front();
                    check("d_rdata", d_rdata, e_d.rdata);
                    if (e_d.is_store) begin
                        check("st_wr_strobes", wr_cnt, 1);
                        check("st_rd_cycles", rd_cnt, 0);
                        check("st_mem_addr", wr_addr, e_d.addr);
                        check("st_mem_wdata", wr_data, e_d.wdata);
                    end else begin
                        check("ld_rd_cycles", rd_cnt, LAT);
                        check("ld_wr_strobes", wr_cnt, 0);
                        check("ld_mem_addr", rd_addr, e_d.addr);
                    end
                end
                rd_cnt = 0; wr_cnt = 0;
            end
        end
    end

    task automatic fetch_driver(input int n);
        int   gap, start, lat;
        bit   done;
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.is_store = 1'b0;
            e.addr     = 32'h200 + ($urandom_range(0, 63) << 2);
            e.wdata    = 32'h0;
            e.rdata    = init_word(e.addr);
            if_q.push_back(e);
            if_req = 1'b1; if_addr = e.addr; start = cyc; done = 1'b0;
            for (int w = 0; w < 40 && !done; w++) begin
                tick();
                if (if_ready) done = 1'b1;
            end
            lat = cyc - start;
            check("if_no_timeout", done, 1'b1);
            check("if_latency_bound", (lat >= LAT + 1) && (lat <= 2 * LAT + 3), 1'b1);
            tick();
            if_req = 1'b0;
            gap = $urandom_range(0, 3);
            repeat (gap) tick();
        end
    endtask

    task automatic data_driver(input int n);
        int   gap, start, lat, op;
        bit   done;
        exp_t e;
        for (int i = 0; i < n; i++) begin
            op         = $urandom_range(0, 2);
            e.addr     = 32'h1000 + ($urandom_range(0, 7) << 2);
            e.wdata    = $urandom;
            e.is_store = (op != 0);
            if (e.is_store) begin
                ref_mem[e.addr] = e.wdata;
                e.rdata = d_last;
            end else begin
                e.rdata = ref_mem.exists(e.addr) ? ref_mem[e.addr] : init_word(e.addr);
                d_last  = e.rdata;
            end
            d_q.push_back(e);
            d_read  = (op == 0) || (op == 2);
            d_write = (op != 0);
            d_addr  = e.addr; d_wdata = e.wdata;
            start = cyc; done = 1'b0;
            for (int w = 0; w < 40 && !done; w++) begin
                tick();
                if (d_ready) done = 1'b1;
            end
            lat = cyc - start;
            check("d_no_timeout", done, 1'b1);
            check("d_latency_bound", (lat >= LAT + 1) && (lat <= 2 * LAT + 3), 1'b1);
            tick();
            d_read = 1'b0; d_write = 1'b0;
            gap = $urandom_range(0, 3);
            repeat (gap) tick();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [15:0] l1_rd, l1_wr, l1_rdy;
    logic [31:0] l1_dd [8];
    logic [31:0] l1_wd [8];
    bit          stray;

    initial begin
        rst = 1'b0;
        if_req = 0; d_read = 0; d_write = 0; if_addr = 0; d_addr = 0; d_wdata = 0;
        l1_if_req = 0; l1_d_read = 0; l1_d_write = 0; l1_if_addr = 0; l1_d_addr = 0; l1_d_wdata = 0;
        repeat (3) tick();
        check("reset_rdata", {if_rdata, d_rdata}, 64'h0);
        check("reset_mem_bus", {mem_addr, mem_wdata}, 64'h0);
        check("reset_flags", {mem_read, mem_write, if_ready, d_ready, pc_hold, pipe_hold}, 6'h0);
        rst = 1'b1;
        phys[32'h40] = 32'h8C220004;
        tick();

        // Contention right after reset: data wins, then fetch.
        if_req = 1; if_addr = 32'h44; d_read = 1; d_addr = 32'h100;
        trace(9);
        check("cont_d_ready", t_dr, 16'h0008);
        check("cont_if_ready", t_ifr, 16'h0080);
        check("cont_mem_read", t_mrd, 16'h0066);
        check("cont_mem_write", t_mwr, 16'h0000);
        check("cont_pipe_hold", t_pph, 16'h0007);
        check("cont_pc_hold", t_pch, 16'h007F);
        check("cont_maddr_d", t_maddr[1], 32'h100);
        check("cont_maddr_if", t_maddr[5], 32'h44);
        check("cont_d_rdata", t_dd[3], init_word(32'h100));
        check("cont_if_rdata", t_ifd[7], init_word(32'h44));

        tick();
        if_req = 1; if_addr = 32'h40;
        trace(5);
        check("fa_mem_read", t_mrd, 16'h0006);
        check("fa_if_ready", t_ifr, 16'h0008);
        check("fa_pc_hold", t_pch, 16'h0007);
        check("fa_pipe_hold", t_pph, 16'h0000);
        check("fa_maddr", t_maddr[1], 32'h40);
        check("fa_if_rdata", t_ifd[3], 32'h8C220004);

        tick();
        d_write = 1; d_addr = 32'h20; d_wdata = 32'hDEADBEEF;
        trace(5);
        check("st_mem_write", t_mwr, 16'h0004);
        check("st_mem_read", t_mrd, 16'h0000);
        check("st_d_ready", t_dr, 16'h0008);
        check("st_pipe_hold", t_pph, 16'h0007);
        check("st_pc_hold", t_pch, 16'h0007);
        check("st_maddr", t_maddr[2], 32'h20);
        check("st_wdata", t_mwd[2], 32'hDEADBEEF);
        check("st_d_rdata_kept", t_dd[4], init_word(32'h100));
        check("st_mem_content", phys_rd(32'h20), 32'hDEADBEEF);

        // Data was granted last, so fetch wins this contest.
        tick();
        if_req = 1; if_addr = 32'h48; d_read = 1; d_addr = 32'h20;
        trace(9);
        check("alt_if_ready", t_ifr, 16'h0008);
        check("alt_d_ready", t_dr, 16'h0080);
        check("alt_if_rdata", t_ifd[3], init_word(32'h48));
        check("alt_d_rdata", t_dd[7], 32'hDEADBEEF);

        // Reset in the first busy cycle of a store.
        tick();
        d_write = 1; d_addr = 32'h30; d_wdata = 32'h12345678;
        tick();
        check("rma_granted", mem_addr, 32'h30);
        rst = 1'b0;
        tick();
        d_write = 1'b0;
        check("rma_rdata", {if_rdata, d_rdata}, 64'h0);
        check("rma_mem_bus", {mem_addr, mem_wdata}, 64'h0);
        check("rma_flags", {mem_read, mem_write, if_ready, d_ready}, 4'h0);
        rst = 1'b1;
        stray = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (mem_write || mem_read || d_ready || if_ready) stray = 1'b1;
        end
        check("rma_no_activity", stray, 1'b0);
        check("rma_no_write", phys.exists(32'h30), 1'b0);

        // Randomized traffic on both ports.
        d_last = 32'h0;
        rd_cnt = 0; wr_cnt = 0;
        mon_en = 1'b1;
        fork
            fetch_driver(60);
            data_driver(60);
        join
        repeat (4) tick();
        mon_en = 1'b0;
        check("if_queue_drained", if_q.size(), 0);
        check("d_queue_drained", d_q.size(), 0);

        // MEM_LAT=1: two held loads back to back.
        l1_rd = '0; l1_wr = '0; l1_rdy = '0;
        l1_d_read = 1; l1_d_addr = 32'h300;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) tick();
            if (k == 3) l1_d_addr = 32'h304;
            if (k == 6) l1_d_read = 1'b0;
            #1;
            l1_rd[k] = l1_mem_read; l1_wr[k] = l1_mem_write; l1_rdy[k] = l1_d_ready;
            l1_dd[k] = l1_d_rdata;
        end
        check("l1_ld_ready", l1_rdy, 16'h0024);
        check("l1_ld_mem_read", l1_rd, 16'h0012);
        check("l1_ld_mem_write", l1_wr, 16'h0000);
        check("l1_ld_rdata0", l1_dd[2], init_word(32'h300));
        check("l1_ld_rdata1", l1_dd[5], init_word(32'h304));

        // MEM_LAT=1: read and write together behave as a store.
        tick();
        l1_rd = '0; l1_wr = '0; l1_rdy = '0;
        l1_d_read = 1; l1_d_write = 1; l1_d_addr = 32'h308; l1_d_wdata = 32'hCAFEF00D;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            if (k == 3) begin l1_d_read = 1'b0; l1_d_write = 1'b0; end
            #1;
            l1_rd[k] = l1_mem_read; l1_wr[k] = l1_mem_write; l1_rdy[k] = l1_d_ready;
            l1_dd[k] = l1_d_rdata; l1_wd[k] = l1_mem_wdata;
        end
        check("l1_rw_mem_write", l1_wr, 16'h0002);
        check("l1_rw_mem_read", l1_rd, 16'h0000);
        check("l1_rw_ready", l1_rdy, 16'h0004);
        check("l1_rw_wdata", l1_wd[1], 32'hCAFEF00D);
        check("l1_rw_rdata_kept", l1_dd[3], init_word(32'h304));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the IF stage (instruction fetch) and the MEM stage (data load/store) of the 5-stage pipeline.
- Sequences each access through a small FSM with a wait-state counter, and returns read data with a one-cycle ready pulse.
- Drives hold signals that freeze the PC/IF_ID path, or the whole pipeline, while an access is outstanding.
- Sits between the pipeline registers and the memory model; the hazard unit ORs its holds into pc_write/IF_ID_write.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 2, memory access cycles per transaction; must be >= 1, and 0 is rejected at elaboration

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-low reset
if_req  in  1  fetch request, held until if_ready
if_addr  in  ADDR_W  fetch address (PC)
if_rdata  out  DATA_W  fetched instruction, registered
if_ready  out  1  one-cycle pulse: fetch complete
d_read  in  1  data load request (EX_MEM mem_read)
d_write  in  1  data store request (EX_MEM mem_write)
d_addr  in  ADDR_W  data address (EX_MEM ALU result)
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data, registered
d_ready  out  1  one-cycle pulse: data access complete
mem_addr  out  ADDR_W  memory address, registered
mem_wdata  out  DATA_W  memory write data, registered
mem_read  out  1  memory read enable
mem_write  out  1  memory write strobe
mem_rdata  in  DATA_W  memory read data, valid in the last access cycle
pc_hold  out  1  hold PC and IF_ID register
pipe_hold  out  1  hold ID_EX, EX_MEM and MEM_WB registers

Behaviour:
- Reset (rst=0 at an edge):
  - state=IDLE, cnt=0, last_grant=IF.
  - All out regs cleared: if_rdata, d_rdata, mem_addr and mem_wdata = 0; mem_read, mem_write, if_ready and d_ready = 0.
  - A reset during an access aborts it. No write strobe is issued afterwards and no ready is produced.
- States: IDLE, IF_BUSY, D_BUSY.
- IDLE:
  - No grant is made in a cycle where if_ready or d_ready is high. This dead cycle lets requesters retire.
  - Otherwise, with a data request (d_read|d_write) and/or if_req:
    - If only one requester is active, it is granted.
    - If both are active, the one that is not last_grant is granted (round-robin). The first contested grant after reset therefore goes to data.
  - On a grant: latch the address, wdata and write flag into mem_* regs; set cnt=MEM_LAT-1; go to the matching BUSY state; update last_grant.
- BUSY (IF_BUSY or D_BUSY):
  - mem_addr is held stable.
  - mem_read=1 for reads for all MEM_LAT cycles.
  - mem_write=1 only in the cycle where cnt==0, giving exactly one write strobe per store.
  - If cnt!=0: cnt decrements each cycle.
  - If cnt==0, at the edge:
    - Reads capture mem_rdata into if_rdata or d_rdata.
    - The matching ready is registered high for one cycle.
    - State returns to IDLE.
- Timing: request sampled in cycle 0; BUSY in cycles 1..MEM_LAT; ready in cycle MEM_LAT+1; next grant possible in cycle MEM_LAT+2. Throughput is one access per MEM_LAT+2 cycles.
- Stores: d_ready pulses; d_rdata is unchanged.
- d_read and d_write both high: treated as a store; the read is ignored.
- Requests dropped while BUSY are ignored; the granted transaction completes.
- Holds (combinational):
  - pc_hold = (if_req & ~if_ready) | pipe_hold
  - pipe_hold = (d_read|d_write) & ~d_ready
- if_rdata and d_rdata hold their last value until the next completing read of the same port.
- MEM_LAT=1: one BUSY cycle, in which cnt==0 immediately.

Decomposition:
- Shared constants header: state encodings (IDLE/IF_BUSY/D_BUSY) and the grant encoding (GRANT_IF/GRANT_D).
- One sub-module: mem_wait_counter (load, decrement, zero flag; width clog2(MEM_LAT)+1).
- The FSM, round-robin arbitration and output regs stay in mem_port_arbiter.

Test Plan:
- Reset mid-access: rst=0 in the 1st BUSY cycle of a store → next cycle mem_write=0, d_ready never pulses, state IDLE, all outputs 0.
- Fetch alone (MEM_LAT=2): if_req=1, if_addr=0x40, mem returns 0x8C220004 → mem_read high in cycles 1-2, if_ready pulse in cycle 3 with if_rdata=0x8C220004; pc_hold=1 in cycles 0-2 and 0 in cycle 3.
- Contention after reset: if_req and d_read (addr 0x100) both in cycle 0 → data granted first, d_ready in cycle 3. Fetch is granted in cycle 4, if_ready in cycle 7. The next contested grant goes to data (alternation holds).
- Store: d_write=1, d_addr=0x20, d_wdata=0xDEADBEEF → mem_write high only in cycle 2 with mem_addr=0x20; d_ready in cycle 3; pipe_hold=1 in cycles 0-2; d_rdata unchanged.
- MEM_LAT=1 back-to-back loads: two loads held → ready in cycles 2 and 5, with exactly one mem_read cycle each. Also d_read and d_write both high → a single write strobe and no d_rdata update.
